// File: rtl/gpu_ci_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : gpu_ci_responder
// Description : Target of the core's CUSTOM-0 GPU port. Executes one command at
//               a time (register bank, 64-bit MAC, kernel launch) and returns
//               one 64-bit response per command.
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_ci_responder #(
    parameter int MUL_LAT = 3,
    parameter int NREGS   = 8,
    parameter int ID_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ci_valid,
    input  logic [7:0]  ci_op,
    input  logic [63:0] ci_arg0,
    input  logic [63:0] ci_arg1,
    output logic        ci_ready,
    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    input  logic        rsp_ready,
    output logic        launch_valid,
    output logic [63:0] launch_pc,
    output logic [63:0] launch_arg,
    input  logic        launch_ready,
    input  logic        kernel_done,
    output logic        kernel_busy,
    output logic        illegal_op
);

    localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int CNT_W = 4;

    localparam logic [7:0]  c_op_nop     = 8'h00;
    localparam logic [7:0]  c_op_reg_wr  = 8'h01;
    localparam logic [7:0]  c_op_reg_rd  = 8'h02;
    localparam logic [7:0]  c_op_mac     = 8'h03;
    localparam logic [7:0]  c_op_acc_clr = 8'h04;
    localparam logic [7:0]  c_op_launch  = 8'h05;
    localparam logic [7:0]  c_op_status  = 8'h06;
    localparam logic [63:0] c_rsp_busy   = 64'hFFFF_FFFF_FFFF_FFFE;
    localparam logic [63:0] c_rsp_illegal = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXEC   = 2'd1,
        S_LAUNCH = 2'd2,
        S_RSP    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [63:0]        r_regs [NREGS];
    logic [63:0]        r_acc;
    logic [63:0]        r_arg0;
    logic [63:0]        r_arg1;
    logic [CNT_W-1:0]   r_cnt;
    logic [63:0]        r_rsp;
    logic               r_launch_valid;
    logic [63:0]        r_launch_pc;
    logic [63:0]        r_launch_arg;
    logic [ID_W-1:0]    r_launch_id;
    logic               r_busy;
    logic               r_illegal;

    logic               w_accept;
    logic               w_handshake;
    logic               w_cnt_last;
    logic [IDX_W-1:0]   w_idx;
    logic [63:0]        w_prod;
    logic [63:0]        w_acc_sum;

    assign w_accept    = ci_valid && (r_state == S_IDLE);
    assign w_handshake = r_launch_valid && launch_ready;
    assign w_cnt_last  = (r_cnt == CNT_W'(1));
    assign w_idx       = ci_arg0[IDX_W-1:0];
    assign w_prod      = r_arg0 * r_arg1;
    assign w_acc_sum   = r_acc + w_prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (ci_op == c_op_mac) begin
                        w_next = S_EXEC;
                    end else if (ci_op == c_op_launch && !r_busy) begin
                        w_next = S_LAUNCH;
                    end else begin
                        w_next = S_RSP;
                    end
                end
            end
            S_EXEC:   if (w_cnt_last)  w_next = S_RSP;
            S_LAUNCH: if (launch_ready) w_next = S_RSP;
            S_RSP:    if (rsp_ready)   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_acc          <= '0;
            r_arg0         <= '0;
            r_arg1         <= '0;
            r_cnt          <= '0;
            r_rsp          <= '0;
            r_launch_valid <= 1'b0;
            r_launch_pc    <= '0;
            r_launch_arg   <= '0;
            r_launch_id    <= '0;
            r_busy         <= 1'b0;
            r_illegal      <= 1'b0;
        end else begin
            r_illegal <= 1'b0;
            // A launch handshake outranks a coincident kernel_done.
            if (w_handshake) begin
                r_busy <= 1'b1;
            end else if (kernel_done) begin
                r_busy <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_arg0 <= ci_arg0;
                        r_arg1 <= ci_arg1;
                        r_cnt  <= CNT_W'(MUL_LAT);
                        case (ci_op)
                            c_op_nop: r_rsp <= '0;
                            c_op_reg_wr: begin
                                r_rsp         <= r_regs[w_idx];
                                r_regs[w_idx] <= ci_arg1;
                            end
                            c_op_reg_rd: r_rsp <= r_regs[w_idx];
                            c_op_mac: begin
                                r_rsp <= r_rsp;
                            end
                            c_op_acc_clr: begin
                                r_rsp <= r_acc;
                                r_acc <= '0;
                            end
                            c_op_launch: begin
                                if (r_busy) begin
                                    r_rsp <= c_rsp_busy;
                                end else begin
                                    r_launch_valid <= 1'b1;
                                    r_launch_pc    <= ci_arg0;
                                    r_launch_arg   <= ci_arg1;
                                end
                            end
                            c_op_status: r_rsp <= {47'b0, r_busy, 16'(r_launch_id)};
                            default: begin
                                r_rsp     <= c_rsp_illegal;
                                r_illegal <= 1'b1;
                            end
                        endcase
                    end
                end
                S_EXEC: begin
                    if (w_cnt_last) begin
                        r_acc <= w_acc_sum;
                        r_rsp <= w_acc_sum;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_LAUNCH: begin
                    if (launch_ready) begin
                        r_launch_valid <= 1'b0;
                        r_rsp          <= 64'(r_launch_id);
                        r_launch_id    <= r_launch_id + ID_W'(1);
                    end
                end
                default: begin
                    r_rsp <= r_rsp;
                end
            endcase
        end
    end

    assign ci_ready     = (r_state == S_IDLE);
    assign rsp_valid    = (r_state == S_RSP);
    assign rsp_data     = r_rsp;
    assign launch_valid = r_launch_valid;
    assign launch_pc    = r_launch_pc;
    assign launch_arg   = r_launch_arg;
    assign kernel_busy  = r_busy;
    assign illegal_op   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_gpu_ci_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_gpu_ci_responder
// Description : Directed plus randomized bench for gpu_ci_responder against a
//               behavioural command model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpu_ci_responder;

    localparam int MUL_LAT = 3;
    localparam int NREGS   = 8;
    localparam int ID_W    = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ci_valid;
    logic [7:0]  ci_op;
    logic [63:0] ci_arg0;
    logic [63:0] ci_arg1;
    logic        ci_ready;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic        rsp_ready;
    logic        launch_valid;
    logic [63:0] launch_pc;
    logic [63:0] launch_arg;
    logic        launch_ready;
    logic        kernel_done;
    logic        kernel_busy;
    logic        illegal_op;

    gpu_ci_responder #(.MUL_LAT(MUL_LAT), .NREGS(NREGS), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ci_valid(ci_valid), .ci_op(ci_op), .ci_arg0(ci_arg0), .ci_arg1(ci_arg1),
        .ci_ready(ci_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .launch_valid(launch_valid), .launch_pc(launch_pc), .launch_arg(launch_arg),
        .launch_ready(launch_ready), .kernel_done(kernel_done),
        .kernel_busy(kernel_busy), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state of the command engine.
    logic [63:0] m_reg [NREGS];
    logic [63:0] m_acc;
    int          m_id;
    bit          m_busy;

    // Observations from the most recent command.
    logic [63:0] g_data;
    int          g_lat, g_ill, g_lv;
    bit          g_stable, g_lstable;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_reg[i] = '0;
        m_acc  = '0;
        m_id   = 0;
        m_busy = 1'b0;
    endtask

    function automatic logic [63:0] model(input logic [7:0] op, input logic [63:0] a0, input logic [63:0] a1);
        int idx;
        logic [63:0] r;
        idx = int'(a0 & 64'(NREGS - 1));
        case (op)
            8'h00: r = '0;
            8'h01: begin r = m_reg[idx]; m_reg[idx] = a1; end
            8'h02: r = m_reg[idx];
            8'h03: begin m_acc = m_acc + a0 * a1; r = m_acc; end
            8'h04: begin r = m_acc; m_acc = '0; end
            8'h05: begin
                if (m_busy) begin
                    r = 64'hFFFF_FFFF_FFFF_FFFE;
                end else begin
                    r = 64'(m_id);
                    m_id = (m_id + 1) % (1 << ID_W);
                    m_busy = 1'b1;
                end
            end
            8'h06: r = {47'b0, m_busy, 16'(m_id)};
            default: r = '1;
        endcase
        return r;
    endfunction

    // Called at a point #1 after a rising edge with the DUT otherwise idle.
    task automatic cmd(input logic [7:0] op, input logic [63:0] a0, input logic [63:0] a1,
                       input int hold, input int ldelay, input bit ldone);
        int budget;
        rsp_ready = (hold == 0);
        ci_op = op; ci_arg0 = a0; ci_arg1 = a1; ci_valid = 1'b1;
        budget = 0;
        while (!ci_ready && budget < 50) begin @(posedge clk); #1; budget++; end
        @(posedge clk); #1;
        ci_valid = 1'b0;
        ci_op = 8'($urandom);
        ci_arg0 = {$urandom, $urandom};
        ci_arg1 = {$urandom, $urandom};
        g_lat = 1; g_ill = 0; g_lv = 0; g_lstable = 1'b1;
        while (!rsp_valid && g_lat < 200) begin
            g_ill += int'(illegal_op);
            if (launch_valid) begin
                g_lv++;
                if (launch_pc !== a0 || launch_arg !== a1) g_lstable = 1'b0;
                if (g_lv > ldelay) begin launch_ready = 1'b1; kernel_done = ldone; end
            end
            @(posedge clk); #1;
            launch_ready = 1'b0; kernel_done = 1'b0;
            g_lat++;
        end
        g_data = rsp_data; g_stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            g_ill += int'(illegal_op);
            if (!rsp_valid || rsp_data !== g_data || ci_ready) g_stable = 1'b0;
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        g_ill += int'(illegal_op);
        if (!rsp_valid || rsp_data !== g_data) g_stable = 1'b0;
        @(posedge clk); #1;
        g_ill += int'(illegal_op);
    endtask

    task automatic do_op(input string tag, input logic [7:0] op, input logic [63:0] a0,
                         input logic [63:0] a1, input int hold = 0, input int ldelay = 0,
                         input bit ldone = 1'b0);
        logic [63:0] exp;
        int exp_lat;
        bit launch_ok, is_ill;
        launch_ok = (op == 8'h05) && !m_busy;
        is_ill    = (op > 8'h06);
        exp       = model(op, a0, a1);
        exp_lat   = (op == 8'h03) ? 1 + MUL_LAT : (launch_ok ? ldelay + 2 : 1);
        cmd(op, a0, a1, hold, ldelay, ldone);
        chk({tag, "/data"}, g_data, exp);
        chk({tag, "/lat"}, 64'(g_lat), 64'(exp_lat));
        chk({tag, "/illegal"}, 64'(g_ill), 64'(is_ill ? 1 : 0));
        if (hold > 0) chk({tag, "/hold"}, 64'(g_stable), 64'd1);
        if (op == 8'h05) begin
            chk({tag, "/lv_cycles"}, 64'(g_lv), 64'(launch_ok ? ldelay + 1 : 0));
            if (launch_ok) chk({tag, "/lv_stable"}, 64'(g_lstable), 64'd1);
        end
        chk({tag, "/busy"}, 64'(kernel_busy), 64'(m_busy));
    endtask

    task automatic kernel_pulse();
        kernel_done = 1'b1;
        @(posedge clk); #1;
        kernel_done = 1'b0;
        m_busy = 1'b0;
    endtask

    initial begin
        int seen;
        logic [7:0] op;
        rst_n = 1'b0; ci_valid = 1'b0; ci_op = '0; ci_arg0 = '0; ci_arg1 = '0;
        rsp_ready = 1'b1; launch_ready = 1'b0; kernel_done = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst/ctl", 64'({ci_ready, rsp_valid, launch_valid, kernel_busy, illegal_op}), 64'b10000);
        chk("rst/rsp_data", rsp_data, 64'd0);
        chk("rst/launch", launch_pc | launch_arg, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("reg_wr3", 8'h01, 64'd3, 64'hDEAD_BEEF);
        do_op("reg_rd3", 8'h02, 64'd3, 64'd0);
        do_op("reg_rd_alias", 8'h02, 64'h13, 64'd0);
        chk("reg_rd_alias/lit", g_data, 64'hDEAD_BEEF);

        do_op("mac3x5", 8'h03, 64'd3, 64'd5);
        chk("mac3x5/lit", g_data, 64'd15);
        do_op("mac_wrap", 8'h03, 64'h1_0000_0000, 64'h1_0000_0000);
        do_op("acc_clr", 8'h04, 64'd0, 64'd0);
        do_op("mac1x1", 8'h03, 64'd1, 64'd1);

        do_op("launch0", 8'h05, 64'h8000_0000, 64'd4, 0, 5);
        do_op("launch_busy", 8'h05, 64'h1234, 64'd1, 0, 0);
        kernel_pulse();
        chk("done/busy", 64'(kernel_busy), 64'd0);
        do_op("launch_collide", 8'h05, 64'h9000_0000, 64'd8, 0, 2, 1'b1);
        do_op("status", 8'h06, 64'd0, 64'd0);
        chk("status/lit", g_data, 64'h1_0002);

        do_op("illegal7f", 8'h7F, 64'd0, 64'd0, 10);

        // Reset while a MAC is executing.
        ci_op = 8'h03; ci_arg0 = 64'd7; ci_arg1 = 64'd9; ci_valid = 1'b1;
        @(posedge clk); #1;
        ci_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst/ctl", 64'({ci_ready, rsp_valid, launch_valid, kernel_busy, illegal_op}), 64'b10000);
        chk("mid_rst/rsp_data", rsp_data, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            seen += int'(rsp_valid);
            @(posedge clk); #1;
        end
        chk("mid_rst/no_rsp", 64'(seen), 64'd0);
        do_op("post_rst_rd", 8'h02, 64'd3, 64'd0);
        do_op("post_rst_mac", 8'h03, 64'd1, 64'd1);
        do_op("post_rst_status", 8'h06, 64'd0, 64'd0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0: op = 8'h00;
                1: op = 8'h01;
                2: op = 8'h02;
                3: op = 8'h03;
                4: op = 8'h04;
                5: op = 8'h05;
                6: op = 8'h06;
                default: op = 8'($urandom_range(7, 255));
            endcase
            if ($urandom_range(0, 3) == 0) kernel_pulse();
            do_op("rand", op, {$urandom, $urandom}, {$urandom, $urandom},
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
